// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot controller: instruction width,
// the EBREAK encoding and the 3-bit controller state encoding.
package boot_ctrl_pkg;

   localparam int INSTRUCTION_SIZE = 32;

   localparam logic [INSTRUCTION_SIZE-1:0] EBREAK_INSN = 32'h00100073;

   typedef enum logic [2:0] {
      BOOT_ST_IDLE    = 3'd0,
      BOOT_ST_LOAD    = 3'd1,
      BOOT_ST_RELEASE = 3'd2,
      BOOT_ST_RUN     = 3'd3,
      BOOT_ST_HALT    = 3'd4
   } boot_state_e;

   // Address width for a memory of the given depth; never narrower than 1 bit.
   function automatic int addr_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/boot_counter.sv
// Saturating up-counter with synchronous clear and enable; clear wins over
// enable, and the count sticks at all-ones instead of wrapping.
module boot_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/boot_ctrl.sv
// Boot controller: streams a program into instruction memory, holds the core
// in reset while loading, runs it until EBREAK and reports the RUN cycle count.
// Define BOOT_WATCHDOG_EN to build the run-cycle watchdog (limit WDT_LIMIT).
module boot_ctrl
   import boot_ctrl_pkg::*;
#(
   parameter int IMEM_WORDS = 256,
   parameter int CNT_W      = 32,
   parameter int WDT_LIMIT  = 100000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              load_valid,
   input  logic [INSTRUCTION_SIZE-1:0]       load_data,
   input  logic                              load_last,
   output logic                              load_ready,
   output logic                              imem_we,
   output logic [addr_w(IMEM_WORDS)-1:0]     imem_addr,
   output logic [INSTRUCTION_SIZE-1:0]       imem_wdata,
   input  logic [INSTRUCTION_SIZE-1:0]       instr,
   output logic                              core_rst,
   output logic                              core_en,
   output logic                              halted,
   output logic                              timeout,
   output logic [CNT_W-1:0]                  cycle_count
);

   localparam int AW = addr_w(IMEM_WORDS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_WORDS - 1);

   // Elaboration-time parameter sanity.
   if ((IMEM_WORDS < 2) || ((IMEM_WORDS & (IMEM_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("boot_ctrl: IMEM_WORDS must be a power of 2 and at least 2");
   end
   if (WDT_LIMIT < 1) begin : g_bad_wdt
      $error("boot_ctrl: WDT_LIMIT must be at least 1");
   end

   boot_state_e   state;
   boot_state_e   state_nxt;
   logic [AW-1:0] ptr;
   logic          xfer;
   logic          ebreak;
   logic          wdt_hit;
   logic          cnt_clr;
   logic          cnt_en;

   assign xfer   = load_valid && load_ready;
   assign ebreak = (instr == EBREAK_INSN);

`ifdef BOOT_WATCHDOG_EN
   assign wdt_hit = (state == BOOT_ST_RUN) && (cycle_count == CNT_W'(WDT_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout <= 1'b0;
      end else if ((state == BOOT_ST_HALT) && start) begin
         timeout <= 1'b0;
      end else if (wdt_hit) begin
         timeout <= 1'b1;
      end
   end
`else
   assign wdt_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT_ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // core_en is combinational so the core freezes in the very cycle it fetches EBREAK.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      core_rst   = 1'b1;
      core_en    = 1'b0;
      halted     = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      case (state)
         BOOT_ST_IDLE: begin
            if (start) state_nxt = BOOT_ST_LOAD;
         end
         BOOT_ST_LOAD: begin
            load_ready = 1'b1;
            if (xfer && (load_last || (ptr == LAST_ADDR))) state_nxt = BOOT_ST_RELEASE;
         end
         BOOT_ST_RELEASE: begin
            cnt_clr   = 1'b1;
            state_nxt = BOOT_ST_RUN;
         end
         BOOT_ST_RUN: begin
            core_rst = 1'b0;
            core_en  = !ebreak && !wdt_hit;
            cnt_en   = 1'b1;
            if (ebreak || wdt_hit) state_nxt = BOOT_ST_HALT;
         end
         BOOT_ST_HALT: begin
            core_rst = 1'b0;
            halted   = 1'b1;
            if (start) state_nxt = BOOT_ST_LOAD;
         end
         default: begin
            state_nxt = BOOT_ST_IDLE;
         end
      endcase
   end

   // Write pointer stops at the last word; leaving LOAD makes the wrap unreachable.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (((state == BOOT_ST_IDLE) || (state == BOOT_ST_HALT)) && start) begin
         ptr <= '0;
      end else if (xfer && (ptr != LAST_ADDR)) begin
         ptr <= ptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= xfer;
         if (xfer) begin
            imem_addr  <= ptr;
            imem_wdata <= load_data;
         end
      end
   end

   boot_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: randomized loads and straight-line programs
// with a behavioural core model, checked against a program-level reference.
module tb_boot_ctrl;

   localparam int WORDS = 8;
   localparam int AW    = 3;
   localparam int CW    = 5;
   localparam int WDT   = 10;
   localparam int CMAX  = 31;
   localparam logic [31:0] EBREAK   = 32'h00100073;
   localparam logic [31:0] JAL_SELF = 32'h0000006f;
`ifdef BOOT_WATCHDOG_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          load_valid = 1'b0;
   logic [31:0]   load_data = '0;
   logic          load_last = 1'b0;
   logic          load_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [31:0]   instr;
   logic          core_rst;
   logic          core_en;
   logic          halted;
   logic          timeout;
   logic [CW-1:0] cycle_count;

   int checks = 0;
   int errors = 0;

   logic [31:0]      prog [WORDS];
   logic [31:0]      mem  [WORDS];
   logic [31:0]      pc;
   logic [AW+31:0]   exp_q [$];
   logic [AW+31:0]   exp_e;

   boot_ctrl #(
      .IMEM_WORDS (WORDS),
      .CNT_W      (CW),
      .WDT_LIMIT  (WDT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .instr       (instr),
      .core_rst    (core_rst),
      .core_en     (core_en),
      .halted      (halted),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL sim_timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int c);
      return (c > CMAX) ? CMAX : c;
   endfunction

   // ---------------- core + memory model ----------------
   assign instr = mem[pc[AW+1:2]];

   always @(posedge clk) begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
      if (core_rst) pc <= '0;
      else if (core_en && (instr != JAL_SELF)) pc <= pc + 32'd4;
   end

   // ---------------- write scoreboard ----------------
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            check("imem_spurious_write", 1, 0);
         end else begin
            exp_e = exp_q.pop_front();
            check("imem_addr", imem_addr, exp_e[AW+31:32]);
            check("imem_wdata", imem_wdata, exp_e[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_values(input string tag);
      check({tag, "_load_ready"}, load_ready, 0);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_core_rst"}, core_rst, 1);
      check({tag, "_core_en"}, core_en, 0);
      check({tag, "_halted"}, halted, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_cycle_count"}, cycle_count, 0);
   endtask

   // Called at a negedge; returns at the first RUN negedge (or abort point).
   task automatic load_prog(input int n, input bit use_last, input int vp, input int abort_after);
      int i = 0;
      int budget = 0;
      bit done = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("core_rst_in_load", core_rst, 1);
      check("halted_in_load", halted, 0);
      check("timeout_in_load", timeout, 0);
      while (!done) begin
         if (budget == 400) begin
            check("load_budget", 0, 1);
            break;
         end
         check("load_ready_in_load", load_ready, 1);
         load_valid = ($urandom_range(0, 99) < vp);
         load_data  = prog[i];
         load_last  = use_last && (i == n - 1);
         start      = ($urandom_range(0, 5) == 0);
         if (load_valid && load_ready) begin
            exp_q.push_back({AW'(i), prog[i]});
            i++;
            if (load_last || (i == WORDS)) done = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         budget++;
         if ((abort_after >= 0) && (i == abort_after)) break;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b0;
      if (done) begin
         check("release_load_ready", load_ready, 0);
         check("release_core_rst", core_rst, 1);
         @(posedge clk);
         @(negedge clk);
         check("run_core_rst", core_rst, 0);
         check("writes_drained", exp_q.size(), 0);
      end
   endtask

   // k = index of the EBREAK in a straight-line program, -1 for none.
   task automatic run_prog(input int k, input int cycles);
      int cnt = 0;
      bit stop = 1'b0;
      bit to = 1'b0;
      bit hit_e;
      bit hit_w;
      logic [31:0] pc_hold;
      while (!stop && (cnt < cycles)) begin
         hit_e = (k >= 0) && (cnt == k);
         hit_w = WDT_ON && (sat(cnt) == WDT - 1);
         check("run_core_rst", core_rst, 0);
         check("run_cycle_count", cycle_count, sat(cnt));
         check("run_core_en", core_en, !(hit_e || hit_w));
         start = ($urandom_range(0, 7) == 0);
         @(posedge clk);
         @(negedge clk);
         cnt++;
         if (hit_e || hit_w) begin
            stop = 1'b1;
            to   = hit_w;
         end
      end
      start = 1'b0;
      if (stop) begin
         pc_hold = pc;
         check("halt_halted", halted, 1);
         check("halt_timeout", timeout, to);
         check("halt_cycle_count", cycle_count, sat(cnt));
         check("halt_core_en", core_en, 0);
         check("halt_core_rst", core_rst, 0);
         if (!to) check("halt_pc", pc, 4 * k);
         repeat (3) @(negedge clk);
         check("halt_hold_halted", halted, 1);
         check("halt_hold_count", cycle_count, sat(cnt));
         check("halt_hold_pc", pc, pc_hold);
      end else begin
         check("running_halted", halted, 0);
         check("running_timeout", timeout, 0);
         check("running_count", cycle_count, sat(cnt));
         check("running_load_ready", load_ready, 0);
         check("ebreak_reached", (k < 0), 1);
      end
   endtask

   task automatic fill_nops();
      for (int j = 0; j < WORDS; j++) begin
         prog[j] = 32'h00000013 | (32'($urandom_range(0, 4095)) << 20);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("rst");
      check("rst_queue_empty", exp_q.size(), 0);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int n;
      int k;
      bit use_last;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      @(negedge clk);
      check("idle_load_ready", load_ready, 0);
      check("idle_core_rst", core_rst, 1);

      // Directed 3-word program, valid held high, EBREAK at index 2.
      prog[0] = 32'h00500093;
      prog[1] = 32'h00100113;
      prog[2] = 32'h00100073;
      load_prog(3, 1'b1, 100, -1);
      run_prog(2, 50);

      // Abort a load after two words, then a full-memory load without load_last.
      fill_nops();
      load_prog(WORDS, 1'b0, 100, 2);
      do_reset();
      fill_nops();
      prog[5] = EBREAK;
      load_prog(WORDS, 1'b0, 50, -1);
      run_prog(5, 60);

      // Random reloads from HALT.
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, WORDS);
         use_last = (n < WORDS) ? 1'b1 : 1'($urandom_range(0, 1));
         k = $urandom_range(0, n - 1);
         fill_nops();
         prog[k] = EBREAK;
         load_prog(n, use_last, $urandom_range(30, 100), -1);
         run_prog(k, 60);
      end

      // Infinite loop: watchdog halt, or saturating count while still running.
      fill_nops();
      prog[0] = JAL_SELF;
      load_prog(1, 1'b1, 70, -1);
      run_prog(-1, 40);
      if (!WDT_ON) do_reset();

      // Final reload clears timeout/halted and restarts the count.
      prog[0] = 32'h00500093;
      prog[1] = EBREAK;
      load_prog(2, 1'b1, 100, -1);
      run_prog(1, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/boot_ctrl.md
Name: boot_ctrl

Overview:
- Sequences the single-cycle RV32I datapath through three phases: program load, run, and halt.
- Accepts instruction words over a valid/ready stream and writes them into instruction memory.
- Holds the core in reset during load, then releases it and gates execution.
- Stops the core on EBREAK and reports the cycle count. Sits between the testbench/host loader and the core top level.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; must be a power of 2.
- CNT_W, 32, width of the run-cycle counter.
- WDT_LIMIT, 100000, run-cycle limit for the watchdog; used only when BOOT_WATCHDOG_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  pulse; begins a load from IDLE or HALT.
- load_valid  input  1  loader word valid.
- load_data  input  `INSTRUCTION_SIZE  instruction word.
- load_last  input  1  marks the final word of the program.
- load_ready  output  1  controller accepts a word this cycle.
- imem_we  output  1  instruction memory write enable (registered).
- imem_addr  output  $clog2(IMEM_WORDS)  word address (registered).
- imem_wdata  output  `INSTRUCTION_SIZE  write data (registered).
- instr  input  `INSTRUCTION_SIZE  instruction currently fetched by the core.
- core_rst  output  1  reset to the core (PC, regfile, data memory).
- core_en  output  1  enables the PC update, regwrite and memwrite in the datapath.
- halted  output  1  core stopped.
- timeout  output  1  watchdog expiry flag.
- cycle_count  output  CNT_W  number of RUN cycles executed.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_rst=1, core_en=0, halted=0, timeout=0, cycle_count=0.
  - rst overrides all activity, including a load or run in progress.
- States: IDLE, LOAD, RELEASE, RUN, HALT. Encoding is 3-bit and lives in the package.
- IDLE:
  - core_rst=1, load_ready=0.
  - start=1 -> LOAD; the internal write pointer is cleared to 0.
- LOAD:
  - load_ready=1 (Moore output), core_rst=1.
  - Handshake: a word transfers when load_valid && load_ready at the clk edge.
  - On a transfer, next cycle: imem_we=1, imem_addr=ptr, imem_wdata=load_data. The pointer then increments. Write latency is 1 cycle.
  - No transfer: imem_we=0 next cycle.
  - Transfer with load_last=1, or transfer at ptr==IMEM_WORDS-1 (memory full): -> RELEASE. Further words are not accepted (load_ready=0 from the next cycle).
  - The pointer does not wrap. A load of exactly IMEM_WORDS words without load_last ends at full.
  - start is ignored while in LOAD.
- RELEASE (1 cycle):
  - core_rst=1, load_ready=0; the final memory write completes this cycle.
  - cycle_count is cleared to 0.
  - -> RUN unconditionally.
- RUN:
  - core_rst=0.
  - core_en is combinational: core_en = (state==RUN) && (instr != EBREAK_INSN).
  - cycle_count increments by 1 each RUN cycle and saturates at all-ones.
  - instr==EBREAK_INSN: core_en=0 in the same cycle, so the PC and architectural state freeze on the EBREAK. -> HALT next edge. The EBREAK cycle is counted.
  - start is ignored in RUN.
- HALT:
  - halted=1, core_en=0, core_rst=0; core state is held for inspection.
  - cycle_count is frozen.
  - start=1 -> LOAD: core_rst=1, halted=0, timeout=0.
- Simultaneous events:
  - rst has priority over everything.
  - In LOAD, a single word with load_last=1 is a valid one-word program.
  - In RUN, EBREAK and watchdog expiry in the same cycle -> HALT with timeout=1.

Optional Feature:
- Macro: BOOT_WATCHDOG_EN.
- Defined:
  - In RUN, when cycle_count == WDT_LIMIT-1 and the core is not yet halting, core_en=0 that cycle.
  - -> HALT with timeout=1 at the next edge.
  - timeout stays set until rst or start.
- Undefined:
  - No watchdog logic is built.
  - timeout is tied to 0.
  - WDT_LIMIT is unused.

Decomposition:
- RISCV_PKG.vh additions:
  - EBREAK_INSN = 32'h00100073.
  - BOOT_ST_IDLE/LOAD/RELEASE/RUN/HALT state encodings.
  - Reuse `INSTRUCTION_SIZE.
- Sub-module boot_counter: a saturating counter with clear and enable, width CNT_W. Used for cycle_count and the watchdog compare.
- FSM and write pointer stay in boot_ctrl.

Test Plan:
- Load of 3 words (0x00500093, 0x00100113, 0x00100073), last on word 3, load_valid held high:
  - imem_we pulses 3 cycles at addr 0,1,2.
  - RELEASE for 1 cycle, then RUN with core_rst=0.
- Program with EBREAK at index 2:
  - Expect core_en=0 in the EBREAK cycle and halted=1 next cycle.
  - Expect cycle_count=3 and the PC frozen at 8.
- load_valid toggling 1/0/1 with IMEM_WORDS=4, no load_last:
  - Only handshaked words are written.
  - After the 4th word, load_ready=0 and the controller enters RELEASE.
- rst asserted mid-LOAD after 2 words:
  - All outputs return to reset values the next cycle.
  - A subsequent start restarts writing at addr 0.
- From HALT, start then reload:
  - core_rst=1 during LOAD, halted and timeout cleared, cycle_count restarts from 0 in RUN.
- BOOT_WATCHDOG_EN, WDT_LIMIT=10, program an infinite loop (0x0000006F):
  - HALT with timeout=1 and cycle_count=10.
  - With the macro undefined, timeout stays 0 and the core keeps running.
